// File: rtl/vec_pkg.sv
// Shared vector datapath definitions: lane geometry, ALU op codes
// and the store-side FSM state encoding.
package vec_pkg;

   localparam int VEC_LANES = 8;
   localparam int VEC_WIDTH = 4;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_MUL = 2'b01,
      ALU_SUB = 2'b10,
      ALU_DIV = 2'b11
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      DONE
   } store_state_t;

endpackage

// File: rtl/vec_lane_sel.sv
// LANES:1 selector returning one lane's element and its mask bit.
module vec_lane_sel #(
   parameter int WIDTH = 4,
   parameter int LANES = 8,
   parameter int IDX_W = 3
) (
   input  logic [LANES*WIDTH-1:0] vec_i,
   input  logic [LANES-1:0]       mask_i,
   input  logic [IDX_W-1:0]       idx_i,
   output logic [WIDTH-1:0]       data_o,
   output logic                   en_o
);

   always_comb begin
      data_o = '0;
      en_o   = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         if (idx_i == IDX_W'(i)) begin
            data_o = vec_i[i*WIDTH +: WIDTH];
            en_o   = mask_i[i];
         end
      end
   end

endmodule

// File: rtl/vec_store_unit.sv
// Captures one ALU result vector and drains its enabled lanes
// into single-element memory writes with a we/ack handshake.
module vec_store_unit
   import vec_pkg::*;
#(
   parameter int WIDTH  = VEC_WIDTH,
   parameter int LANES  = VEC_LANES,
   parameter int ADDR_W = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*WIDTH-1:0] in_vec,
   input  logic [LANES-1:0]       in_mask,
   input  logic [ADDR_W-1:0]      in_base,
   output logic                   mem_we,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic [WIDTH-1:0]       mem_wdata,
   input  logic                   mem_ack,
   output logic                   busy,
   output logic                   done
);

   localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(LANES - 1);

   store_state_t             state_q, state_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [LANES*WIDTH-1:0]   vec_q, vec_d;
   logic [LANES-1:0]         mask_q, mask_d;
   logic [ADDR_W-1:0]        base_q, base_d;

   logic [WIDTH-1:0]         lane_data;
   logic                     lane_en;

   vec_lane_sel #(
      .WIDTH (WIDTH),
      .LANES (LANES),
      .IDX_W (IDX_W)
   ) u_sel (
      .vec_i  (vec_q),
      .mask_i (mask_q),
      .idx_i  (idx_q),
      .data_o (lane_data),
      .en_o   (lane_en)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         vec_q   <= '0;
         mask_q  <= '0;
         base_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         vec_q   <= vec_d;
         mask_q  <= mask_d;
         base_q  <= base_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      vec_d   = vec_q;
      mask_d  = mask_q;
      base_d  = base_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               vec_d   = in_vec;
               mask_d  = in_mask;
               base_d  = in_base;
               idx_d   = '0;
               state_d = (in_mask == '0) ? DONE : WRITE;
            end
         end
         WRITE: begin
            // Masked-off lanes burn one cycle so the cost stays fixed.
            if (!lane_en || mem_ack) begin
               if (idx_q == LAST) begin
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q == WRITE) || (state_q == DONE);
   assign done      = (state_q == DONE);
   assign mem_we    = (state_q == WRITE) && lane_en;
   assign mem_addr  = (state_q == WRITE) ? base_q + ADDR_W'(idx_q) : '0;
   assign mem_wdata = (state_q == WRITE) ? lane_data : '0;

endmodule

// File: tb/tb_vec_store_unit.sv
// Directed bench for vec_store_unit: timing, stall, mask, wrap, reset.
module tb_vec_store_unit;

   localparam int W = 4;
   localparam int L = 8;
   localparam int A = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic [L*W-1:0] in_vec = '0;
   logic [L-1:0]   in_mask = '0;
   logic [A-1:0]   in_base = '0;
   logic           in_ready;
   logic           mem_we;
   logic [A-1:0]   mem_addr;
   logic [W-1:0]   mem_wdata;
   logic           mem_ack;
   logic           busy;
   logic           done;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [A-1:0] stall_addr = 8'h12;
   int stall_total = 0;
   int hold_cnt = 0;
   int stall_seen = 0;
   int stall_bad = 0;

   int           wr_cyc[$];
   logic [A-1:0] wr_addr[$];
   logic [W-1:0] wr_data[$];
   int           done_cyc[$];

   vec_store_unit #(.WIDTH(W), .LANES(L), .ADDR_W(A)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .in_mask   (in_mask),
      .in_base   (in_base),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   assign mem_ack = !(mem_we && mem_addr == stall_addr
                      && hold_cnt < stall_total);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_we && mem_addr == stall_addr) hold_cnt <= hold_cnt + 1;
      else hold_cnt <= 0;
   end

   always @(negedge clk) begin
      if (mem_we && mem_ack) begin
         wr_cyc.push_back(cyc);
         wr_addr.push_back(mem_addr);
         wr_data.push_back(mem_wdata);
      end
      if (done) done_cyc.push_back(cyc);
      if (mem_we && mem_addr == stall_addr && stall_total > 0) begin
         stall_seen <= stall_seen + 1;
         if (mem_wdata !== 4'h3) stall_bad <= stall_bad + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   task automatic send(input logic [L*W-1:0] v, input logic [L-1:0] m,
                       input logic [A-1:0] b, output int e0);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL send_ready got=%b want=1", in_ready);
      end
      in_vec = v;
      in_mask = m;
      in_base = b;
      in_valid = 1'b1;
      e0 = cyc + 1;
      @(negedge clk);
      in_valid = 1'b0;
      in_vec = ~v;
      in_mask = ~m;
      in_base = ~b;
   endtask

   task automatic wait_ready(output int rc);
      int n;
      n = 0;
      while (!in_ready && n < 60) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL wait_ready timeout got=%b want=1", in_ready);
      end
      rc = cyc;
   endtask

   task automatic test_reset;
      checks++;
      if ({in_ready, mem_we, mem_addr, mem_wdata, busy, done}
          !== {1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_outputs got rdy=%b we=%b a=%h d=%h b=%b dn=%b want 1 0 00 0 0 0",
                  in_ready, mem_we, mem_addr, mem_wdata, busy, done);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({in_ready, mem_we, busy, done} !== 4'b1000) begin
         failures++;
         $display("FAIL idle_after_reset got=%b want=1000",
                  {in_ready, mem_we, busy, done});
      end
   endtask

   task automatic test_full;
      int s, d, e0, rc;
      s = wr_cyc.size();
      d = done_cyc.size();
      send({8{4'h3}}, 8'hFF, 8'h10, e0);
      checks++;
      if ({busy, in_ready} !== 2'b10) begin
         failures++;
         $display("FAIL full_busy got=%b want=10", {busy, in_ready});
      end
      wait_ready(rc);
      checks++;
      if (wr_cyc.size() - s != 8) begin
         failures++;
         $display("FAIL full_count got=%0d want=8", wr_cyc.size() - s);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (wr_addr[s+i] !== 8'(8'h10 + i) || wr_data[s+i] !== 4'h3
             || wr_cyc[s+i] != e0 + i) begin
            failures++;
            $display("FAIL full_lane%0d got a=%h d=%h c=%0d want a=%h d=3 c=%0d",
                     i, wr_addr[s+i], wr_data[s+i], wr_cyc[s+i] - e0,
                     8'(8'h10 + i), i);
         end
      end
      checks++;
      if (done_cyc.size() - d != 1 || done_cyc[d] != e0 + 8) begin
         failures++;
         $display("FAIL full_done got n=%0d c=%0d want n=1 c=8",
                  done_cyc.size() - d, done_cyc[d] - e0);
      end
      checks++;
      if (rc != e0 + 9) begin
         failures++;
         $display("FAIL full_ready got=%0d want=9", rc - e0);
      end
   endtask

   task automatic test_stall;
      int s, d, e0, rc, ss, sb;
      s = wr_cyc.size();
      d = done_cyc.size();
      ss = stall_seen;
      sb = stall_bad;
      stall_total = 3;
      send({8{4'h3}}, 8'hFF, 8'h10, e0);
      wait_ready(rc);
      @(negedge clk);
      stall_total = 0;
      checks++;
      if (wr_cyc.size() - s != 8 || wr_addr[s+2] !== 8'h12
          || wr_cyc[s+2] != e0 + 5 || wr_cyc[s+3] != e0 + 6) begin
         failures++;
         $display("FAIL stall_lane2 got n=%0d a=%h c=%0d want n=8 a=12 c=5",
                  wr_cyc.size() - s, wr_addr[s+2], wr_cyc[s+2] - e0);
      end
      checks++;
      if (stall_seen - ss != 4 || stall_bad != sb) begin
         failures++;
         $display("FAIL stall_hold got cycles=%0d bad=%0d want cycles=4 bad=0",
                  stall_seen - ss, stall_bad - sb);
      end
      checks++;
      if (done_cyc.size() - d != 1 || done_cyc[d] != e0 + 11) begin
         failures++;
         $display("FAIL stall_done got c=%0d want c=11", done_cyc[d] - e0);
      end
   endtask

   task automatic test_mask;
      int s, d, e0, rc;
      int lanes[4];
      lanes = '{0, 2, 5, 7};
      s = wr_cyc.size();
      d = done_cyc.size();
      send(32'h7654_3210, 8'hA5, 8'h00, e0);
      wait_ready(rc);
      checks++;
      if (wr_cyc.size() - s != 4) begin
         failures++;
         $display("FAIL mask_count got=%0d want=4", wr_cyc.size() - s);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (wr_addr[s+k] !== 8'(lanes[k]) || wr_data[s+k] !== 4'(lanes[k])
             || wr_cyc[s+k] != e0 + lanes[k]) begin
            failures++;
            $display("FAIL mask_w%0d got a=%h d=%h c=%0d want a=%h d=%h c=%0d",
                     k, wr_addr[s+k], wr_data[s+k], wr_cyc[s+k] - e0,
                     8'(lanes[k]), 4'(lanes[k]), lanes[k]);
         end
      end
      checks++;
      if (done_cyc.size() - d != 1 || done_cyc[d] != e0 + 8) begin
         failures++;
         $display("FAIL mask_done got c=%0d want c=8", done_cyc[d] - e0);
      end
   endtask

   task automatic test_zero_mask;
      int s, d, e0, rc;
      s = wr_cyc.size();
      d = done_cyc.size();
      send(32'hFFFF_FFFF, 8'h00, 8'h33, e0);
      checks++;
      if ({done, busy, mem_we} !== 3'b110) begin
         failures++;
         $display("FAIL zero_done_cycle got=%b want=110", {done, busy, mem_we});
      end
      wait_ready(rc);
      checks++;
      if (wr_cyc.size() != s || done_cyc.size() - d != 1
          || done_cyc[d] != e0 || rc != e0 + 1) begin
         failures++;
         $display("FAIL zero_mask got w=%0d dc=%0d rc=%0d want w=0 dc=0 rc=1",
                  wr_cyc.size() - s, done_cyc[d] - e0, rc - e0);
      end
   endtask

   task automatic test_wrap;
      int s, e0, rc;
      s = wr_cyc.size();
      send(32'h89AB_CDEF, 8'hFF, 8'hFC, e0);
      wait_ready(rc);
      checks++;
      if (wr_cyc.size() - s != 8) begin
         failures++;
         $display("FAIL wrap_count got=%0d want=8", wr_cyc.size() - s);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (wr_addr[s+i] !== 8'(252 + i) || wr_data[s+i] !== 4'(15 - i)) begin
            failures++;
            $display("FAIL wrap_lane%0d got a=%h d=%h want a=%h d=%h",
                     i, wr_addr[s+i], wr_data[s+i], 8'(252 + i), 4'(15 - i));
         end
      end
   endtask

   task automatic test_reset_mid;
      int s, d, e0, rc;
      d = done_cyc.size();
      send({8{4'h1}}, 8'hFF, 8'h40, e0);
      repeat (4) @(negedge clk);
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 8'h44) begin
         failures++;
         $display("FAIL rst_lane4 got we=%b a=%h want we=1 a=44", mem_we, mem_addr);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({mem_we, busy, done, in_ready} !== 4'b0001 || mem_addr !== 8'h00) begin
         failures++;
         $display("FAIL rst_async got we/b/dn/rdy=%b a=%h want 0001 a=00",
                  {mem_we, busy, done, in_ready}, mem_addr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (done_cyc.size() != d) begin
         failures++;
         $display("FAIL rst_no_done got=%0d want=0", done_cyc.size() - d);
      end
      s = wr_cyc.size();
      d = done_cyc.size();
      send(32'h0000_0005, 8'h01, 8'h80, e0);
      wait_ready(rc);
      checks++;
      if (wr_cyc.size() - s != 1 || wr_addr[s] !== 8'h80
          || wr_data[s] !== 4'h5 || wr_cyc[s] != e0) begin
         failures++;
         $display("FAIL rst_next got n=%0d a=%h d=%h c=%0d want n=1 a=80 d=5 c=0",
                  wr_cyc.size() - s, wr_addr[s], wr_data[s], wr_cyc[s] - e0);
      end
      checks++;
      if (done_cyc.size() - d != 1 || done_cyc[d] != e0 + 8) begin
         failures++;
         $display("FAIL rst_next_done got c=%0d want c=8", done_cyc[d] - e0);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      test_reset();
      test_full();
      test_stall();
      test_mask();
      test_zero_mask();
      test_wrap();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
